// File: rtl/ram_dma_if.sv
// Request and RAM-port signal bundle for ram_dma.
// The slave modport is the DMA engine; master is the requester and RAM side.
interface ram_dma_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          start;
    logic          mode;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [AW-1:0] len;
    logic [DW-1:0] fill_val;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_abus;
    logic [DW-1:0] mem_dbus_i;
    logic [DW-1:0] mem_dbus_o;
    logic          mem_wr_en;

    modport slave (
        input  start, mode, src, dst, len, fill_val, mem_dbus_i,
        output busy, done, mem_abus, mem_dbus_o, mem_wr_en
    );

    modport master (
        output start, mode, src, dst, len, fill_val, mem_dbus_i,
        input  busy, done, mem_abus, mem_dbus_o, mem_wr_en
    );
endinterface

// File: rtl/ram_dma.sv
// Single-port RAM DMA engine: forward copy (READ/WRITE pairs) or constant fill.
// RAM read is asynchronous, so each READ cycle captures data at its closing edge.
module ram_dma #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic     clk,
    input  logic     rst,
    ram_dma_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t        state, state_nx;
    logic          mode_q;
    logic [AW-1:0] src_ptr, dst_ptr, cnt;
    logic [DW-1:0] fill_q, hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            mode_q  <= 1'b0;
            src_ptr <= '0;
            dst_ptr <= '0;
            cnt     <= '0;
            fill_q  <= '0;
            hold    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (bus.start) begin
                    mode_q  <= bus.mode;
                    src_ptr <= bus.src;
                    dst_ptr <= bus.dst;
                    cnt     <= bus.len;
                    fill_q  <= bus.fill_val;
                end
                READ: begin
                    hold    <= bus.mem_dbus_i;
                    src_ptr <= src_ptr + 1'b1;
                end
                WRITE: begin
                    dst_ptr <= dst_ptr + 1'b1;
                    cnt     <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // cnt still holds the pre-decrement value in WRITE, so 1 means last word.
    always_comb begin
        state_nx       = state;
        bus.busy       = 1'b0;
        bus.done       = 1'b0;
        bus.mem_abus   = '0;
        bus.mem_dbus_o = '0;
        bus.mem_wr_en  = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                if (bus.len == '0) state_nx = DONE;
                else               state_nx = bus.mode ? WRITE : READ;
            end
            READ: begin
                bus.busy     = 1'b1;
                bus.mem_abus = src_ptr;
                state_nx     = WRITE;
            end
            WRITE: begin
                bus.busy       = 1'b1;
                bus.mem_abus   = dst_ptr;
                bus.mem_dbus_o = mode_q ? fill_q : hold;
                bus.mem_wr_en  = 1'b1;
                if (cnt == AW'(1)) state_nx = DONE;
                else               state_nx = mode_q ? WRITE : READ;
            end
            DONE: begin
                bus.done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: doc/ram_dma.md
RAM_DMA -- requirements
Module: ram_dma

Interface
REQ-001 Parameter: AW, 8, address width of the RAM port, src/dst pointers and len.
REQ-002 Parameter: DW, 8, data width of the RAM port and fill value.
REQ-003 Port: clk  input  1  single clock; all state changes on posedge clk.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: start  input  1  request pulse; sampled only in IDLE.
REQ-006 Port: mode  input  1  0 = copy src->dst, 1 = fill dst with fill_val; sampled with start.
REQ-007 Port: src  input  AW  copy source start address; sampled with start.
REQ-008 Port: dst  input  AW  destination start address; sampled with start.
REQ-009 Port: len  input  AW  word count; sampled with start; 0 = no transfer.
REQ-010 Port: fill_val  input  DW  fill data; sampled with start.
REQ-011 Port: busy  output  1  high while a transfer is in progress.
REQ-012 Port: done  output  1  one-cycle completion pulse.
REQ-013 Port: mem_abus  output  AW  RAM address; drives the RAM abus.
REQ-014 Port: mem_dbus_i  input  DW  RAM read data; driven by RAM dbus_o (async read, same cycle).
REQ-015 Port: mem_dbus_o  output  DW  RAM write data; drives RAM dbus_i.
REQ-016 Port: mem_wr_en  output  1  RAM write enable; RAM writes on the posedge where it is high.

Function
REQ-017 The FSM SHALL have the states IDLE, READ, WRITE and DONE.
REQ-018 In IDLE, start=1 at a posedge SHALL latch mode, src, dst, len and fill_val into internal registers.
REQ-019 On that edge, len=0 SHALL go to DONE; len!=0 with mode=0 SHALL go to READ; len!=0 with mode=1 SHALL go to WRITE.
REQ-020 READ SHALL drive mem_abus=src_ptr and mem_wr_en=0, capture mem_dbus_i into a hold register at the edge, increment src_ptr, and go to WRITE.
REQ-021 WRITE SHALL drive mem_abus=dst_ptr and mem_wr_en=1.
REQ-022 WRITE SHALL drive mem_dbus_o from the hold register when mode=0 and from the latched fill_val when mode=1.
REQ-023 At the WRITE edge, the block SHALL increment dst_ptr and decrement the count.
REQ-024 From WRITE, count reaching 0 SHALL go to DONE; otherwise mode=0 SHALL go to READ and mode=1 SHALL stay in WRITE.
REQ-025 DONE SHALL assert done=1 for exactly one cycle and then go to IDLE.
REQ-026 busy SHALL be 1 in READ and WRITE, and 0 in IDLE and DONE.
REQ-027 Latency from the start edge to the done cycle SHALL be: copy 2*len+1 cycles; fill len+1 cycles; len=0, 1 cycle.
REQ-028 src_ptr and dst_ptr SHALL wrap modulo 2^AW (0xFF+1 -> 0x00) with no error indication.
REQ-029 Copy SHALL always proceed in ascending address order; overlapping regions produce the forward-copy result (dst>src overlap replicates data).
REQ-030 start while not in IDLE (READ, WRITE, DONE) SHALL be ignored, and the latched parameters SHALL be unaffected.
REQ-031 start asserted in the DONE cycle SHALL be ignored; a new request is accepted from IDLE on the next edge.
REQ-032 Input changes after the start edge SHALL have no effect on the transfer in progress.
REQ-033 In IDLE and DONE, outputs SHALL be mem_abus=0, mem_dbus_o=0 and mem_wr_en=0.
REQ-034 mem_wr_en SHALL be high only in WRITE, and never for more than len cycles per transfer.

Reset
REQ-035 rst=1 SHALL immediately (asynchronously) force IDLE, busy=0, done=0, mem_wr_en=0, mem_abus=0 and mem_dbus_o=0, and clear all pointers, count and hold registers to 0.
REQ-036 rst asserted mid-transfer SHALL abort the transfer; no further write occurs; words already written remain in RAM; no done pulse is produced.
REQ-037 After rst deasserts, the first posedge SHALL sample start normally.

Verification
REQ-038 Copy: RAM[0x10..0x13]=AA,BB,CC,DD; start mode=0 src=0x10 dst=0x40 len=4 -> RAM[0x40..0x43]=AA,BB,CC,DD; done 9 cycles after the start edge; busy high for 8 cycles.
REQ-039 Fill with wrap: start mode=1 dst=0xFE len=3 fill_val=0x5A -> RAM[0xFE]=RAM[0xFF]=RAM[0x00]=0x5A; RAM[0x01] unchanged; done 4 cycles after start.
REQ-040 Zero length: start len=0 -> done on the next cycle; busy never high; mem_wr_en never high.
REQ-041 Overlap: RAM[0x20]=11, RAM[0x21]=22; copy src=0x20 dst=0x21 len=2 -> RAM[0x21]=11, RAM[0x22]=11.
REQ-042 Ignored start: during a len=4 copy, pulse start with dst=0x80 -> only the original dst range is written; exactly one done pulse.
REQ-043 Reset mid-operation: assert rst after the 2nd WRITE of a len=4 fill -> only 2 words are written; outputs are at reset values within the same cycle; no done pulse; a subsequent start works normally.
